simmem_resp_release_bank: RTL and testbench



---
 rtl/simmem_pkg.sv | 10 +
 rtl/simmem_rr_picker.sv | 35 +++
 rtl/simmem_resp_release_bank.sv | 114 +++++++++++
 tb/tb_simmem_resp_release_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared parameters and types for the simulated-memory write-response path.
// Used by the response release bank and its round-robin picker.
package simmem_pkg;

   localparam int unsigned WriteRespBankTotalCapacity = 8;
   localparam int unsigned WriteRespWidth             = 8;

   typedef logic [WriteRespWidth-1:0] write_resp_t;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req_i       - multihot request vector
//   ptr_i       - index that has the highest priority; the search wraps past Width-1
//   grant_o     - one-hot of the selected request (zero if none)
//   grant_idx_o - binary index of the selected request (zero if none)
//   any_grant_o - at least one request is set
module simmem_rr_picker #(
   parameter  int unsigned Width = 8,
   localparam int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
   input  logic [Width-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [Width-1:0] grant_o,
   output logic [IdxW-1:0]  grant_idx_o,
   output logic             any_grant_o
);

   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant_o     = '0;
      grant_idx_o = '0;
      any_grant_o = 1'b0;
      for (int off = 0; off < int'(Width); off++) begin
         idx = (int'(ptr_i) + off) % Width;
         if (!any_grant_o && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = IdxW'(idx);
            any_grant_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simmem_resp_release_bank.sv
// Storage-and-release end of the simulated-memory write-response path.
// Each accepted response lands in the lowest free slot; the slot index goes to
// the delay bank. When the delay bank marks a slot releasable, one slot per cycle
// is picked round-robin and moved into a registered valid/ready output stage.
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   in_data_i/in_valid_i      - incoming response payload
//   in_ready_o                - a free slot exists
//   local_identifier_o        - slot index allocated on this cycle's handshake
//   release_en_i              - per-slot releasable flags from the delay bank
//   address_released_onehot_o - slot moved to the output stage this cycle
//   out_data_o/out_valid_o    - registered output stage
//   out_ready_i               - downstream accepts
module simmem_resp_release_bank
   import simmem_pkg::*;
#(
   parameter  int unsigned Capacity  = WriteRespBankTotalCapacity,
   parameter  int unsigned RespWidth = WriteRespWidth,
   localparam int unsigned IdxW      = (Capacity > 1) ? $clog2(Capacity) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [RespWidth-1:0] in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [Capacity-1:0]  local_identifier_o,
   input  logic [Capacity-1:0]  release_en_i,
   output logic [Capacity-1:0]  address_released_onehot_o,
   output logic [RespWidth-1:0] out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   logic [Capacity-1:0]  valid_q, valid_d;
   logic [RespWidth-1:0] data_q [Capacity];
   logic [IdxW-1:0]      rr_q, rr_d;
   logic                 out_valid_q, out_valid_d;
   logic [RespWidth-1:0] out_data_q, out_data_d;

   logic [IdxW-1:0]      alloc_idx;
   logic                 alloc;
   logic [Capacity-1:0]  candidates;
   logic [Capacity-1:0]  pick_onehot;
   logic [IdxW-1:0]      pick_idx;
   logic                 any_pick;
   logic                 load;

   // Allocation looks only at registered valid_q, so in_ready_o never depends
   // on in_valid_i and a freed slot becomes usable the cycle after release.
   always_comb begin
      alloc_idx = '0;
      for (int i = int'(Capacity) - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx = IdxW'(i);
      end
   end

   assign in_ready_o         = ~&valid_q;
   assign local_identifier_o = Capacity'(alloc_idx);
   assign alloc              = in_valid_i & in_ready_o;

   assign candidates = release_en_i & valid_q;

   simmem_rr_picker #(
      .Width(Capacity)
   ) u_picker (
      .req_i      (candidates),
      .ptr_i      (rr_q),
      .grant_o    (pick_onehot),
      .grant_idx_o(pick_idx),
      .any_grant_o(any_pick)
   );

   assign load                      = any_pick & (~out_valid_q | out_ready_i);
   assign address_released_onehot_o = load ? pick_onehot : '0;

   always_comb begin
      valid_d     = valid_q;
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (alloc) valid_d[alloc_idx] = 1'b1;
      if (load) begin
         valid_d[pick_idx] = 1'b0;
         out_valid_d       = 1'b1;
         out_data_d        = data_q[pick_idx];
         rr_d              = (pick_idx == IdxW'(Capacity - 1)) ? '0 : pick_idx + IdxW'(1);
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q     <= '0;
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         valid_q     <= valid_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Payload storage needs no reset: a slot is only read after valid_q is set.
   always_ff @(posedge clk_i) begin
      if (alloc) data_q[alloc_idx] <= in_data_i;
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_simmem_resp_release_bank.sv
module tb_simmem_resp_release_bank;
   import simmem_pkg::*;

   localparam int CAP = WriteRespBankTotalCapacity;
   localparam int RW  = WriteRespWidth;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic [RW-1:0]  in_data_i = '0;
   logic           in_valid_i = 1'b0;
   logic           in_ready_o;
   logic [CAP-1:0] local_identifier_o;
   logic [CAP-1:0] release_en_i = '0;
   logic [CAP-1:0] address_released_onehot_o;
   logic [RW-1:0]  out_data_o;
   logic           out_valid_o;
   logic           out_ready_i = 1'b0;

   int checks = 0;
   int failures = 0;

   simmem_resp_release_bank dut (
      .clk_i                    (clk_i),
      .rst_ni                   (rst_ni),
      .in_data_i                (in_data_i),
      .in_valid_i               (in_valid_i),
      .in_ready_o               (in_ready_o),
      .local_identifier_o       (local_identifier_o),
      .release_en_i             (release_en_i),
      .address_released_onehot_o(address_released_onehot_o),
      .out_data_o               (out_data_o),
      .out_valid_o              (out_valid_o),
      .out_ready_i              (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: a set of occupied slots with their payloads, a rotating
   // priority index and a single-entry output buffer.
   bit            m_occ [CAP];
   logic [RW-1:0] m_pay [CAP];
   int            m_next;
   bit            m_ov;
   logic [RW-1:0] m_od;

   function automatic logic [CAP-1:0] occ_vec();
      logic [CAP-1:0] v;
      v = '0;
      for (int i = 0; i < CAP; i++) v[i] = m_occ[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CAP; i++) m_occ[i] = 0;
      m_next = 0;
      m_ov   = 0;
      m_od   = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, compare all outputs against the model 1 time unit
   // later, then advance the model across the rising edge.
   task automatic step(input bit inv, input logic [RW-1:0] d, input logic [CAP-1:0] rel,
                       input bit ordy);
      int            free_slot;
      int            pick;
      bit            do_load;
      logic [CAP-1:0] exp_oh;
      in_valid_i   = inv;
      in_data_i    = d;
      release_en_i = rel & occ_vec();
      out_ready_i  = ordy;
      #1;
      free_slot = -1;
      for (int i = 0; i < CAP && free_slot < 0; i++) if (!m_occ[i]) free_slot = i;
      pick = -1;
      for (int k = 0; k < CAP && pick < 0; k++)
         if (release_en_i[(m_next + k) % CAP] && m_occ[(m_next + k) % CAP]) pick = (m_next + k) % CAP;
      do_load = (pick >= 0) && (!m_ov || ordy);
      exp_oh  = do_load ? (CAP'(1) << pick) : '0;
      chk("in_ready", 32'(in_ready_o), 32'(free_slot >= 0));
      chk("local_id", 32'(local_identifier_o), 32'((free_slot >= 0) ? free_slot : 0));
      chk("rel_onehot", 32'(address_released_onehot_o), 32'(exp_oh));
      chk("out_valid", 32'(out_valid_o), 32'(m_ov));
      if (m_ov) chk("out_data", 32'(out_data_o), 32'(m_od));
      @(posedge clk_i);
      if (do_load) begin
         m_od        = m_pay[pick];
         m_ov        = 1;
         m_occ[pick] = 0;
         m_next      = (pick + 1) % CAP;
      end else if (m_ov && ordy) begin
         m_ov = 0;
      end
      if (inv && free_slot >= 0) begin
         m_occ[free_slot] = 1;
         m_pay[free_slot] = d;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_data", 32'(out_data_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst_local_id", 32'(local_identifier_o), 32'd0);
      chk("rst_onehot", 32'(address_released_onehot_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // Three pushes, nothing released.
      in_data_i = 8'h11; in_valid_i = 1'b1; #1;
      chk("push0_id", 32'(local_identifier_o), 32'd0);
      step(1, 8'h11, '0, 1);
      chk("push1_id", 32'(local_identifier_o), 32'd1);
      step(1, 8'h22, '0, 1);
      chk("push2_id", 32'(local_identifier_o), 32'd2);
      step(1, 8'h33, '0, 1);
      chk("push_no_out", 32'(out_valid_o), 32'd0);

      // Single release of slot 1.
      release_en_i = CAP'(3'b010); out_ready_i = 1'b1; in_valid_i = 1'b0; #1;
      chk("rel1_onehot", 32'(address_released_onehot_o), 32'h2);
      step(0, 8'h00, CAP'(3'b010), 1);
      chk("rel1_data", 32'(out_data_o), 32'h22);
      chk("rel1_valid", 32'(out_valid_o), 32'd1);
      chk("rel1_realloc_id", 32'(local_identifier_o), 32'd1);
      step(0, 8'h00, '0, 1);

      // Three back-to-back releases starting from priority index 0.
      do_reset();
      step(1, 8'h11, '0, 1);
      step(1, 8'h22, '0, 1);
      step(1, 8'h33, '0, 1);
      for (int i = 0; i < 3; i++) begin
         release_en_i = CAP'(3'b111) & occ_vec(); #1;
         chk("b2b_onehot", 32'(address_released_onehot_o), 32'(1) << i);
         step(0, 8'h00, CAP'(3'b111), 1);
         chk("b2b_data", 32'(out_data_o), 32'(8'h11 * (i + 1)));
      end
      step(0, 8'h00, '0, 1);

      // Fill all slots, release one, reuse its index.
      do_reset();
      for (int i = 0; i < CAP; i++) step(1, RW'($urandom), '0, 1);
      chk("full_ready", 32'(in_ready_o), 32'd0);
      step(0, 8'h00, CAP'(1) << 5, 1);
      chk("free_ready", 32'(in_ready_o), 32'd1);
      chk("free_id", 32'(local_identifier_o), 32'd5);
      step(1, 8'h5a, '0, 1);
      chk("refull_ready", 32'(in_ready_o), 32'd0);

      // Wrap: priority index at CAP-1 after releasing CAP-2.
      step(0, 8'h00, CAP'(1) << (CAP - 2), 1);
      release_en_i = (CAP'(1) << (CAP - 1)) | CAP'(1); #1;
      chk("wrap_pick", 32'(address_released_onehot_o), 32'(1) << (CAP - 1));
      step(0, 8'h00, (CAP'(1) << (CAP - 1)) | CAP'(1), 1);
      step(0, 8'h00, CAP'(1), 1);
      step(0, 8'h00, '0, 1);

      // Back-pressure with two pending releases.
      do_reset();
      step(1, 8'ha1, '0, 0);
      step(1, 8'hb2, '0, 0);
      step(1, 8'hc3, '0, 0);
      step(0, 8'h00, CAP'(1), 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 8'h00, CAP'(3'b110), 0);
         chk("bp_data", 32'(out_data_o), 32'ha1);
      end
      step(0, 8'h00, CAP'(3'b110), 1);
      chk("bp_drain1", 32'(out_data_o), 32'hb2);
      step(0, 8'h00, CAP'(3'b110), 1);
      chk("bp_drain2", 32'(out_data_o), 32'hc3);
      step(0, 8'h00, '0, 1);

      // Reset mid-operation with slots held and output stage full.
      step(1, 8'h01, '0, 0);
      step(1, 8'h02, '0, 0);
      step(1, 8'h03, '0, 0);
      step(1, 8'h04, CAP'(1), 0);
      release_en_i = '1;
      do_reset();
      chk("post_rst_id", 32'(local_identifier_o), 32'd0);
      step(1, 8'h77, '0, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++)
         step(bit'($urandom_range(0, 1)), RW'($urandom), CAP'($urandom),
              $urandom_range(0, 3) != 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
